// File: rtl/myproject_mul_pkg.sv
// Shared types and helpers for the pipelined multiplier/accumulator.
package myproject_mul_pkg;

  localparam int unsigned MaxDoutW = 64;

  typedef struct packed {
    logic                valid;
    logic                last;
    logic [MaxDoutW-1:0] product;
  } stage_t;

  // A signed product of operands extended by one sign bit never needs more than this.
  function automatic int unsigned prod_width(input int unsigned w0, input int unsigned w1);
    return w0 + w1 + 1;
  endfunction

  // p is already sign-extended to MaxDoutW, so keeping the low w bits both truncates
  // (narrow result) and sign-extends (wide result).
  function automatic logic [MaxDoutW-1:0] map_dout(input logic [MaxDoutW-1:0] p,
                                                   input int unsigned w);
    logic [MaxDoutW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MaxDoutW; i++) begin
      if (i < w) r[i] = p[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_mul_pipe_stage.sv
// One pipeline register stage carrying a stage record, with enable and async reset.
module myproject_mul_pipe_stage
  import myproject_mul_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/myproject_mul_pipe_acc.sv
// Pipelined multiplier with optional grouped accumulation at the final stage.
module myproject_mul_pipe_acc
  import myproject_mul_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH  = 3,
  parameter int unsigned DIN1_WIDTH  = 9,
  parameter int unsigned DOUT_WIDTH  = 10,
  parameter int unsigned NUM_STAGE   = 3,
  parameter int unsigned DIN0_SIGNED = 0,
  parameter int unsigned DIN1_SIGNED = 0,
  parameter int unsigned ACC_EN      = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned ExtW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  logic signed [ExtW-1:0] op0_ext, op1_ext, prod_ext;
  logic [MaxDoutW-1:0]    prod_sx;
  stage_t                 in_rec, tail_in, tail_d;
  stage_t                 stage_q [NUM_STAGE];
  logic [DOUT_WIDTH-1:0]  acc_q, acc_d, tail_sum;
  logic                   unused_bits;

  // The whole pipeline moves as one; it only freezes when the output is held.
  assign in_ready = !(out_valid && !out_ready);

  always_comb begin
    if (DIN0_SIGNED != 0) op0_ext = ExtW'(signed'(din0));
    else                  op0_ext = ExtW'(din0);
    if (DIN1_SIGNED != 0) op1_ext = ExtW'(signed'(din1));
    else                  op1_ext = ExtW'(din1);
    prod_ext = op0_ext * op1_ext;
    prod_sx  = MaxDoutW'(prod_ext);
    in_rec   = '{valid: in_valid, last: in_last, product: map_dout(prod_sx, DOUT_WIDTH)};
  end

  if (NUM_STAGE == 1) begin : g_tail_from_input
    assign tail_in = in_rec;
  end else begin : g_tail_from_pipe
    assign tail_in = stage_q[NUM_STAGE-2];
  end

  // Accumulation is folded into the input of the last register stage.
  always_comb begin
    tail_sum = acc_q + tail_in.product[DOUT_WIDTH-1:0];
    tail_d   = tail_in;
    acc_d    = acc_q;
    if (ACC_EN != 0) begin
      tail_d.valid   = tail_in.valid && tail_in.last;
      tail_d.product = MaxDoutW'(tail_sum);
      if (tail_in.valid) acc_d = tail_in.last ? '0 : tail_sum;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q <= '0;
    end else if (in_ready) begin
      acc_q <= acc_d;
    end
  end

  for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
    stage_t d;
    if (i == NUM_STAGE - 1) begin : g_tail
      assign d = tail_d;
    end else if (i == 0) begin : g_head
      assign d = in_rec;
    end else begin : g_mid
      assign d = stage_q[i-1];
    end

    myproject_mul_pipe_stage u_stage (
      .clk_i  (ap_clk),
      .rst_ni (ap_rst_n),
      .en_i   (in_ready),
      .d_i    (d),
      .q_o    (stage_q[i])
    );
  end

  assign out_valid = stage_q[NUM_STAGE-1].valid;
  assign dout      = stage_q[NUM_STAGE-1].product[DOUT_WIDTH-1:0];

  assign unused_bits = ^{stage_q[NUM_STAGE-1].last, stage_q[NUM_STAGE-1].product, tail_sum};

endmodule

// File: tb/tb_myproject_mul_pipe_acc.sv
// Directed and randomised scoreboard bench for myproject_mul_pipe_acc across several configs.
module tb_myproject_mul_pipe_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Default config
  logic [2:0] a_din0; logic [8:0] a_din1; logic a_vld, a_last, a_irdy, a_ov, a_ordy;
  logic [9:0] a_dout; logic [9:0] a_q[$];
  // Both operands signed, 16-bit result
  logic [2:0] b_din0; logic [8:0] b_din1; logic b_vld, b_last, b_irdy, b_ov, b_ordy;
  logic [15:0] b_dout; logic [15:0] b_q[$];
  // Accumulate mode
  logic [2:0] c_din0; logic [8:0] c_din1; logic c_vld, c_last, c_irdy, c_ov, c_ordy;
  logic [9:0] c_dout; logic [9:0] c_q[$]; logic [9:0] c_acc_m;
  // 32x32 mixed signedness, 64-bit result
  logic [31:0] d_din0, d_din1; logic d_vld, d_last, d_irdy, d_ov, d_ordy;
  logic [63:0] d_dout; logic [63:0] d_q[$];
  // 1x1, 8-bit result, accumulate, deep pipeline
  logic [0:0] e_din0, e_din1; logic e_vld, e_last, e_irdy, e_ov, e_ordy;
  logic [7:0] e_dout; logic [7:0] e_q[$]; logic [7:0] e_acc_m;

  bit seen;
  int nb, nd, ne;

  myproject_mul_pipe_acc u_def (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(a_din0), .din1(a_din1), .in_valid(a_vld),
    .in_last(a_last), .in_ready(a_irdy), .dout(a_dout), .out_valid(a_ov), .out_ready(a_ordy)
  );

  myproject_mul_pipe_acc #(.DOUT_WIDTH(16), .DIN0_SIGNED(1), .DIN1_SIGNED(1)) u_sgn (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(b_din0), .din1(b_din1), .in_valid(b_vld),
    .in_last(b_last), .in_ready(b_irdy), .dout(b_dout), .out_valid(b_ov), .out_ready(b_ordy)
  );

  myproject_mul_pipe_acc #(.ACC_EN(1)) u_acc (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(c_din0), .din1(c_din1), .in_valid(c_vld),
    .in_last(c_last), .in_ready(c_irdy), .dout(c_dout), .out_valid(c_ov), .out_ready(c_ordy)
  );

  myproject_mul_pipe_acc #(.DIN0_WIDTH(32), .DIN1_WIDTH(32), .DOUT_WIDTH(64), .NUM_STAGE(2),
                           .DIN0_SIGNED(1)) u_wide (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(d_din0), .din1(d_din1), .in_valid(d_vld),
    .in_last(d_last), .in_ready(d_irdy), .dout(d_dout), .out_valid(d_ov), .out_ready(d_ordy)
  );

  myproject_mul_pipe_acc #(.DIN0_WIDTH(1), .DIN1_WIDTH(1), .DOUT_WIDTH(8), .NUM_STAGE(8),
                           .DIN0_SIGNED(1), .ACC_EN(1)) u_nar (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(e_din0), .din1(e_din1), .in_valid(e_vld),
    .in_last(e_last), .in_ready(e_irdy), .dout(e_dout), .out_valid(e_ov), .out_ready(e_ordy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wide_model(input logic [31:0] x, input logic [31:0] y);
    logic signed [64:0] ex, ey, ep;
    ex = {{33{x[31]}}, x};
    ey = {33'd0, y};
    ep = ex * ey;
    return ep[63:0];
  endfunction

  // Output monitors: every transferred result must match the head of its scoreboard.
  always @(negedge clk) begin
    if (rst_n && a_ov && a_ordy) begin
      check("def_pending", 64'(a_q.size() != 0), 64'd1);
      if (a_q.size() != 0) check("def_dout", 64'(a_dout), 64'(a_q.pop_front()));
    end
    if (rst_n && b_ov && b_ordy) begin
      check("sgn_pending", 64'(b_q.size() != 0), 64'd1);
      if (b_q.size() != 0) check("sgn_dout", 64'(b_dout), 64'(b_q.pop_front()));
    end
    if (rst_n && c_ov && c_ordy) begin
      check("acc_pending", 64'(c_q.size() != 0), 64'd1);
      if (c_q.size() != 0) check("acc_dout", 64'(c_dout), 64'(c_q.pop_front()));
    end
    if (rst_n && d_ov && d_ordy) begin
      check("wide_pending", 64'(d_q.size() != 0), 64'd1);
      if (d_q.size() != 0) check("wide_dout", d_dout, d_q.pop_front());
    end
    if (rst_n && e_ov && e_ordy) begin
      check("nar_pending", 64'(e_q.size() != 0), 64'd1);
      if (e_q.size() != 0) check("nar_dout", 64'(e_dout), 64'(e_q.pop_front()));
    end
  end

  task automatic send_def(input logic [2:0] x, input logic [8:0] y, input logic [9:0] exp);
    bit ok = 1'b0;
    a_din0 = x; a_din1 = y; a_vld = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (a_irdy) begin ok = 1'b1; a_q.push_back(exp); end
      @(posedge clk); #1;
    end
    a_vld = 1'b0;
    check("def_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_sgn(input logic [2:0] x, input logic [8:0] y, input logic [15:0] exp);
    bit ok = 1'b0;
    b_din0 = x; b_din1 = y; b_vld = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (b_irdy) begin ok = 1'b1; b_q.push_back(exp); end
      @(posedge clk); #1;
    end
    b_vld = 1'b0;
    check("sgn_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_acc(input logic [2:0] x, input logic [8:0] y, input logic last);
    bit ok = 1'b0;
    c_din0 = x; c_din1 = y; c_last = last; c_vld = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (c_irdy) begin
        ok = 1'b1;
        c_acc_m = c_acc_m + 10'(int'(x) * int'(y));
        if (last) begin c_q.push_back(c_acc_m); c_acc_m = '0; end
      end
      @(posedge clk); #1;
    end
    c_vld = 1'b0; c_last = 1'b0;
    check("acc_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 100 &&
         (a_q.size() + b_q.size() + c_q.size() + d_q.size() + e_q.size()) != 0; k++) begin
      @(negedge clk);
    end
    check(tag, 64'(a_q.size() + b_q.size() + c_q.size() + d_q.size() + e_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {a_din0, a_din1, a_vld, a_last} = '0; a_ordy = 1'b1;
    {b_din0, b_din1, b_vld, b_last} = '0; b_ordy = 1'b1;
    {c_din0, c_din1, c_vld, c_last} = '0; c_ordy = 1'b1; c_acc_m = '0;
    {d_din0, d_din1, d_vld, d_last} = '0; d_ordy = 1'b1;
    {e_din0, e_din1, e_vld, e_last} = '0; e_ordy = 1'b1; e_acc_m = '0;
    #1;
    check("rst_def_ov",   64'(a_ov),   64'd0);
    check("rst_def_dout", 64'(a_dout), 64'd0);
    check("rst_def_irdy", 64'(a_irdy), 64'd1);
    check("rst_acc_ov",   64'(c_ov),   64'd0);
    check("rst_acc_dout", 64'(c_dout), 64'd0);
    check("rst_wide_ov",  64'(d_ov),   64'd0);
    check("rst_wide_dout", d_dout,     64'd0);
    check("rst_nar_irdy", 64'(e_irdy), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 7 * 511 = 3577 -> 505 modulo 1024, visible exactly three cycles after acceptance
    send_def(3'd7, 9'd511, 10'd505);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("def_latency_ov", 64'(a_ov), 64'(i == 3));
    end
    @(posedge clk); #1;

    // Ten back-to-back beats with the consumer stalled in cycles 4..7
    nb = 0;
    for (int k = 0; k < 40 && (nb < 10 || a_q.size() != 0); k++) begin
      @(posedge clk); #1;
      a_ordy = !(k >= 4 && k <= 7);
      a_vld  = (nb < 10);
      a_din0 = 3'(nb);
      a_din1 = 9'(37 * nb + 5);
      @(negedge clk);
      if (k >= 4 && k <= 7) begin
        check("stall_irdy", 64'(a_irdy), 64'd0);
        check("stall_ov",   64'(a_ov),   64'd1);
        if (a_q.size() != 0) check("stall_dout", 64'(a_dout), 64'(a_q[0]));
      end
      if (a_vld && a_irdy) begin
        a_q.push_back(10'(int'(a_din0) * int'(a_din1)));
        nb++;
      end
    end
    @(posedge clk); #1;
    a_vld = 1'b0; a_ordy = 1'b1;
    check("stream_beats", 64'(nb), 64'd10);
    drain("stream_drain");

    // Signed operands: -1 * 5 and 3 * -1
    send_sgn(3'b111, 9'd5, 16'hFFFB);
    send_sgn(3'd3, 9'h1FF, 16'hFFFD);
    drain("sgn_drain");

    // Accumulation groups: 6 + 20 + 1 = 27, then a fresh group of one giving 42
    send_acc(3'd2, 9'd3, 1'b0);
    send_acc(3'd4, 9'd5, 1'b0);
    send_acc(3'd1, 9'd1, 1'b1);
    send_acc(3'd6, 9'd7, 1'b1);
    drain("acc_drain");

    // Reset in the middle of a partial group while a result is held at the output
    c_ordy = 1'b0;
    send_acc(3'd1, 9'd2, 1'b1);
    send_acc(3'd2, 9'd3, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = c_ov;
    end
    check("acc_hold_ov", 64'(seen), 64'd1);
    if (c_q.size() != 0) check("acc_hold_dout", 64'(c_dout), 64'(c_q[0]));
    #1 rst_n = 1'b0;
    #1;
    check("arst_acc_ov",   64'(c_ov),   64'd0);
    check("arst_acc_dout", 64'(c_dout), 64'd0);
    check("arst_acc_irdy", 64'(c_irdy), 64'd1);
    c_q.delete();
    c_acc_m = '0;
    #1;
    rst_n = 1'b1;
    c_din0 = 3'd1; c_din1 = 9'd1; c_last = 1'b1; c_vld = 1'b1;
    c_q.push_back(10'd1);
    @(posedge clk); #1;
    c_vld = 1'b0; c_last = 1'b0; c_ordy = 1'b1;
    drain("arst_drain");

    // Random traffic on the corner-width configs
    nd = 0; ne = 0;
    for (int k = 0; k < 60000 && (nd < 10000 || ne < 10000); k++) begin
      @(posedge clk); #1;
      d_vld  = (nd < 10000) && ($urandom_range(3) != 0);
      d_din0 = $urandom;
      d_din1 = $urandom;
      d_ordy = ($urandom_range(3) != 0);
      e_vld  = (ne < 10000) && ($urandom_range(3) != 0);
      e_din0 = 1'($urandom);
      e_din1 = 1'($urandom);
      e_last = ($urandom_range(3) == 0);
      e_ordy = ($urandom_range(3) != 0);
      @(negedge clk);
      if (d_vld && d_irdy) begin
        d_q.push_back(wide_model(d_din0, d_din1));
        nd++;
      end
      if (e_vld && e_irdy) begin
        e_acc_m = e_acc_m + ((e_din0[0] && e_din1[0]) ? 8'hFF : 8'h00);
        if (e_last) begin e_q.push_back(e_acc_m); e_acc_m = '0; end
        ne++;
      end
    end
    @(posedge clk); #1;
    d_vld = 1'b0; e_vld = 1'b0; d_ordy = 1'b1; e_ordy = 1'b1;
    check("rand_wide_beats", 64'(nd), 64'd10000);
    check("rand_nar_beats",  64'(ne), 64'd10000);
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/myproject_mul_pipe_acc.md
MYPROJECT_MUL_PIPE_ACC -- requirements
Module: myproject_mul_pipe_acc

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 3, operand 0 width (1..32).
REQ-002 SHALL have parameter DIN1_WIDTH, default 9, operand 1 width (1..32).
REQ-003 SHALL have parameter DOUT_WIDTH, default 10, result width (1..64).
REQ-004 SHALL have parameter NUM_STAGE, default 3, pipeline depth in cycles (1..8).
REQ-005 SHALL have parameters DIN0_SIGNED and DIN1_SIGNED, default 0, operand signedness (0 unsigned, 1 two's complement).
REQ-006 SHALL have parameter ACC_EN, default 0, accumulate mode enable.
REQ-007 SHALL have ports:
ap_clk  input  1  clock, all state on rising edge
ap_rst_n  input  1  asynchronous active-low reset
din0  input  DIN0_WIDTH  operand 0
din1  input  DIN1_WIDTH  operand 1
in_valid  input  1  operands valid
in_last  input  1  final beat of accumulation group (ignored when ACC_EN=0)
in_ready  output  1  block accepts operands
dout  output  DOUT_WIDTH  product or accumulated sum
out_valid  output  1  dout valid
out_ready  input  1  consumer accepts dout

Function
REQ-008 SHALL extend each operand to DIN0_WIDTH+DIN1_WIDTH+1 bits (sign-extend if its SIGNED parameter is 1, zero-extend otherwise) and form a signed full-precision product.
REQ-009 SHALL map the full product to DOUT_WIDTH: keep low DOUT_WIDTH bits when narrower, sign-extend when wider.
REQ-010 SHALL accept a beat when in_valid && in_ready in the same cycle.
REQ-011 SHALL drive in_ready = !(out_valid && !out_ready); the whole pipeline advances as one when in_ready is 1 and holds all stages otherwise.
REQ-012 SHALL, with ACC_EN=0 and no stall, present the product of a beat accepted in cycle N with out_valid=1 in cycle N+NUM_STAGE.
REQ-013 SHALL keep dout and out_valid stable while out_valid && !out_ready.
REQ-014 SHALL carry a per-stage valid bit; bubbles SHALL propagate with valid=0 and never raise out_valid.
REQ-015 SHALL, with ACC_EN=1, add each product (DOUT_WIDTH-mapped) into a DOUT_WIDTH accumulator at the last pipeline stage, wrapping modulo 2^DOUT_WIDTH.
REQ-016 SHALL, with ACC_EN=1, raise out_valid only for the beat with in_last=1, outputting accumulator-plus-that-product, and clear the accumulator to 0 in the same advance.
REQ-017 SHALL, with ACC_EN=1, treat a single beat with in_last=1 as a group of one (dout = its product).
REQ-018 SHALL sustain one beat per cycle at out_ready=1 in both modes.

Reset
REQ-019 SHALL on ap_rst_n=0 immediately clear all stage valid bits, out_valid, accumulator and dout to 0, independent of ap_clk.
REQ-020 SHALL discard all in-flight beats and any partial accumulation group on reset; in_ready SHALL be 1 while and after reset is deasserted.
REQ-021 SHALL synchronise reset deassertion is the integrator's responsibility; block SHALL accept a beat on the first rising edge with ap_rst_n=1.

Structure
REQ-022 SHALL place in shared package myproject_mul_pkg: function computing extended product width, function for DOUT_WIDTH truncate/sign-extend mapping, and the stage record typedef (valid, last, product).
REQ-023 SHALL instantiate NUM_STAGE copies of sub-module myproject_mul_pipe_stage (one register stage with enable and async reset); multiplication occurs before stage 1 so synthesis can retime into DSP pipeline registers.

Verification
REQ-024 SHALL cover: defaults, din0=7, din1=511, in_valid one cycle -> dout=505 (3577 mod 1024), out_valid exactly 3 cycles later for one cycle.
REQ-025 SHALL cover: DIN0_SIGNED=1, din0=3'b111, din1=5 -> dout=10'h3FB (-5); DIN1_SIGNED=1, DOUT_WIDTH=16, din0=3, din1=9'h1FF -> dout=16'hFFFD.
REQ-026 SHALL cover: back-to-back stream of 10 beats with out_ready held 0 for cycles 4-7 -> in_ready low while stalled, no beat lost or duplicated, outputs in order, dout stable during stall.
REQ-027 SHALL cover: ACC_EN=1, beats (2,3),(4,5),(1,1,last) then (6,7,last) -> exactly two outputs, dout=27 then 42, accumulator restarted from 0.
REQ-028 SHALL cover: ACC_EN=1, ap_rst_n pulsed low after (2,3) accepted, then (1,1,last) -> out_valid falls asynchronously, single output dout=1.
REQ-029 SHALL cover: random operands, random in_valid/out_ready, all parameter corner widths (1 and 32) -> scoreboard match against reference model, zero mismatches over 10000 beats.
